// File: rtl/sw_operand_capture.sv
// sw_operand_capture: synchronises the slide switches and the KEY_N pushbutton,
// debounces the button, and captures operand A, then operand B plus carry-in,
// over two presses. The captured set is offered to the adder through a
// valid/ready handshake.
// Build option: define SW_OPERAND_DEBOUNCE_EN to enable the KEY_N debounce
// counter. When it is undefined, key_stable follows key_sync every cycle,
// which keeps simulation fast.
module sw_operand_capture #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [17:0] SW,
  input  logic        KEY_N,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  output logic        op_cin,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    CAPT_A  = 2'b00,
    CAPT_B  = 2'b01,
    PRESENT = 2'b10
  } state_t;

  // Reject parameter values that would break the synchroniser or the debouncer.
  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("sw_operand_capture: DEBOUNCE_CYCLES and SYNC_STAGES must be >= 2");
  end

  // Only SW[17] (clear), SW[8] (carry-in) and SW[3:0] (value) are used.
  logic       unused_sw;
  logic [5:0] sw_raw;
  assign unused_sw = ^{SW[16:9], SW[7:4]};
  assign sw_raw    = {SW[17], SW[8], SW[3:0]};

  logic [5:0]             sw_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] key_sync_q;
  logic [5:0]             sw_sync;
  logic                   key_sync;
  logic                   clear;
  logic                   cin_sync;
  logic [3:0]             val_sync;

  assign sw_sync  = sw_sync_q[SYNC_STAGES-1];
  assign key_sync = key_sync_q[SYNC_STAGES-1];
  assign clear    = sw_sync[5];
  assign cin_sync = sw_sync[4];
  assign val_sync = sw_sync[3:0];

  // Switch synchroniser chain. Switches read as 0 after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  // Key synchroniser chain. The key reads as released (1) after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) key_sync_q <= '1;
    else        key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], KEY_N};
  end

  logic key_stable;

`ifdef SW_OPERAND_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt;

  // Accept a new key level only after it has differed from the stable level
  // for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      key_stable <= 1'b1;
      db_cnt     <= '0;
    end else if (key_sync == key_stable) begin
      db_cnt     <= '0;
    end else if (db_cnt == CNT_LAST) begin
      key_stable <= key_sync;
      db_cnt     <= '0;
    end else begin
      db_cnt     <= db_cnt + CNT_W'(1);
    end
  end
`else
  // No filtering: the stable level simply follows the synchronised key.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) key_stable <= 1'b1;
    else        key_stable <= key_sync;
  end
`endif

  logic key_prev;
  logic press;

  assign press = key_prev & ~key_stable;

  // Remember the previous stable level so a 1->0 step yields a single pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) key_prev <= 1'b1;
    else        key_prev <= key_stable;
  end

  state_t     state_q, state_d;
  logic [3:0] op_a_d, op_b_d;
  logic       op_cin_d, op_valid_d;

  assign state = state_q;

  // State and operand registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q  <= CAPT_A;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a     <= op_a_d;
      op_b     <= op_b_d;
      op_cin   <= op_cin_d;
      op_valid <= op_valid_d;
    end
  end

  // Capture sequencing and handshake. Clear overrides everything else.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a;
    op_b_d     = op_b;
    op_cin_d   = op_cin;
    op_valid_d = op_valid;
    case (state_q)
      CAPT_A: begin
        op_valid_d = 1'b0;
        if (press) begin
          op_a_d  = val_sync;
          state_d = CAPT_B;
        end
      end
      CAPT_B: begin
        op_valid_d = 1'b0;
        if (press) begin
          op_b_d     = val_sync;
          op_cin_d   = cin_sync;
          op_valid_d = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        op_valid_d = 1'b1;
        if (op_valid && op_ready) begin
          op_valid_d = 1'b0;
          state_d    = CAPT_A;
        end
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = CAPT_A;
      end
    endcase
    if (clear) begin
      state_d    = CAPT_A;
      op_a_d     = '0;
      op_b_d     = '0;
      op_cin_d   = 1'b0;
      op_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_operand_capture.sv
// tb_sw_operand_capture: directed test of sw_operand_capture with
// DEBOUNCE_CYCLES = 4 and SYNC_STAGES = 2. Expected latencies follow the
// SW_OPERAND_DEBOUNCE_EN build option.
module tb_sw_operand_capture;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
`ifdef SW_OPERAND_DEBOUNCE_EN
  localparam int PRESS_LAT = SYNC + DEB;
`else
  localparam int PRESS_LAT = SYNC + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] sw;
  logic        key_n;
  logic        op_ready;
  logic [3:0]  op_a, op_b;
  logic        op_cin, op_valid;
  logic [1:0]  state;

  int check_count = 0;
  int fail_count  = 0;

  sw_operand_capture #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50(clk),
    .RST_N   (rst_n),
    .SW      (sw),
    .KEY_N   (key_n),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_cin  (op_cin),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .state   (state)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [17:0] sw_val, input logic key_val,
                               input logic ready_val);
    sw       = sw_val;
    key_n    = key_val;
    op_ready = ready_val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold the key low for low_cycles, release it, then let the release settle.
  task automatic pressKey(input int low_cycles, input int settle);
    key_n = 1'b0;
    tick(low_cycles);
    key_n = 1'b1;
    tick(settle);
  endtask

  // Pulse the clear switch long enough to pass the synchroniser.
  task automatic clearOps();
    sw[17] = 1'b1;
    tick(4);
    sw[17] = 1'b0;
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(18'h0, 1'b1, 1'b1);
    tick(3);
    rst_n = 1'b1;
    $display("[TB] reset values");
    checkOutput("rst_op_a", 32'(op_a), 32'h0);
    checkOutput("rst_op_b", 32'(op_b), 32'h0);
    checkOutput("rst_cin", 32'(op_cin), 32'h0);
    checkOutput("rst_valid", 32'(op_valid), 32'h0);
    checkOutput("rst_state", 32'(state), 32'h0);

    $display("[TB] basic capture with op_ready high");
    applyStimulus(18'h00005, 1'b0, 1'b1);
    tick(PRESS_LAT);
    checkOutput("a_latency_before", 32'(state), 32'h0);
    tick(1);
    checkOutput("a_latency_at", 32'(state), 32'h1);
    checkOutput("a_value", 32'(op_a), 32'h5);
    tick(10 - PRESS_LAT - 1);
    key_n = 1'b1;
    tick(12);
    checkOutput("a_no_repeat", 32'(state), 32'h1);
    applyStimulus(18'h00103, 1'b0, 1'b1);
    tick(PRESS_LAT + 1);
    checkOutput("b_state", 32'(state), 32'h2);
    checkOutput("b_valid", 32'(op_valid), 32'h1);
    checkOutput("b_value", 32'(op_b), 32'h3);
    checkOutput("b_cin", 32'(op_cin), 32'h1);
    checkOutput("b_keeps_a", 32'(op_a), 32'h5);
    tick(1);
    checkOutput("pulse_valid_low", 32'(op_valid), 32'h0);
    checkOutput("pulse_state", 32'(state), 32'h0);
    key_n = 1'b1;
    tick(12);

    $display("[TB] backpressure");
    applyStimulus(18'h0000A, 1'b1, 1'b0);
    pressKey(8, 10);
    applyStimulus(18'h00106, 1'b1, 1'b0);
    pressKey(8, 10);
    for (int i = 0; i < 3; i++) begin
      sw = 18'(i + 1);
      pressKey(8, 10);
    end
    checkOutput("bp_valid", 32'(op_valid), 32'h1);
    checkOutput("bp_state", 32'(state), 32'h2);
    checkOutput("bp_a", 32'(op_a), 32'hA);
    checkOutput("bp_b", 32'(op_b), 32'h6);
    checkOutput("bp_cin", 32'(op_cin), 32'h1);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    checkOutput("bp_xfer_valid", 32'(op_valid), 32'h0);
    checkOutput("bp_xfer_state", 32'(state), 32'h0);

    $display("[TB] short glitch");
    sw = 18'h0000C;
    pressKey(3, 12);
`ifdef SW_OPERAND_DEBOUNCE_EN
    checkOutput("glitch_state", 32'(state), 32'h0);
    checkOutput("glitch_a", 32'(op_a), 32'hA);
`else
    checkOutput("glitch_state", 32'(state), 32'h1);
    checkOutput("glitch_a", 32'(op_a), 32'hC);
`endif
    clearOps();
    checkOutput("clear_state", 32'(state), 32'h0);
    checkOutput("clear_a", 32'(op_a), 32'h0);

    $display("[TB] six-cycle press");
    sw = 18'h00007;
    key_n = 1'b0;
    tick(PRESS_LAT);
    checkOutput("six_before", 32'(state), 32'h0);
    if (PRESS_LAT >= 6) key_n = 1'b1;
    tick(1);
    checkOutput("six_at", 32'(state), 32'h1);
    checkOutput("six_a", 32'(op_a), 32'h7);
    if (PRESS_LAT < 6) begin
      tick(6 - PRESS_LAT - 1);
      key_n = 1'b1;
    end
    tick(12);

    $display("[TB] clear during capture of B");
    clearOps();
    sw = 18'h00009;
    pressKey(8, 10);
    checkOutput("clr_pre_state", 32'(state), 32'h1);
    checkOutput("clr_pre_a", 32'(op_a), 32'h9);
    applyStimulus(18'h20005, 1'b0, 1'b0);
    tick(5);
    applyStimulus(18'h00005, 1'b1, 1'b0);
    tick(12);
    checkOutput("clr_state", 32'(state), 32'h0);
    checkOutput("clr_a", 32'(op_a), 32'h0);
    checkOutput("clr_b", 32'(op_b), 32'h0);
    sw = 18'h00008;
    pressKey(8, 10);
    checkOutput("clr_after_state", 32'(state), 32'h1);
    checkOutput("clr_after_a", 32'(op_a), 32'h8);

    $display("[TB] synchronous reset");
    clearOps();
    sw = 18'h0000F;
    pressKey(8, 10);
    sw = 18'h0010F;
    pressKey(8, 10);
    checkOutput("rst_pre_state", 32'(state), 32'h2);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick(1);
    checkOutput("rst_glitch_state", 32'(state), 32'h2);
    checkOutput("rst_glitch_valid", 32'(op_valid), 32'h1);
    checkOutput("rst_glitch_a", 32'(op_a), 32'hF);
    checkOutput("rst_glitch_b", 32'(op_b), 32'hF);
    key_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    key_n = 1'b1;
    tick(1);
    rst_n = 1'b1;
    checkOutput("srst_a", 32'(op_a), 32'h0);
    checkOutput("srst_b", 32'(op_b), 32'h0);
    checkOutput("srst_cin", 32'(op_cin), 32'h0);
    checkOutput("srst_valid", 32'(op_valid), 32'h0);
    checkOutput("srst_state", 32'(state), 32'h0);
    tick(12);
    checkOutput("srst_press_lost", 32'(state), 32'h0);

    $display("[TB] one-cycle press");
    sw = 18'h00003;
    key_n = 1'b0;
    tick(1);
    key_n = 1'b1;
`ifdef SW_OPERAND_DEBOUNCE_EN
    tick(12);
    checkOutput("one_cycle_state", 32'(state), 32'h0);
    checkOutput("one_cycle_a", 32'(op_a), 32'h0);
`else
    tick(PRESS_LAT - 1);
    checkOutput("one_cycle_before", 32'(state), 32'h0);
    tick(1);
    checkOutput("one_cycle_state", 32'(state), 32'h1);
    checkOutput("one_cycle_a", 32'(op_a), 32'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
